// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Wide-operand adder that reuses one 4-bit ripple-carry slice. The slice
//   processes one nibble per cycle, starting at the least significant nibble.
//   A carry register links the nibbles from one cycle to the next.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request present on a/b/cin
//   in_ready   controller idle and able to take a request (registered)
//   a, b       WIDTH-bit operands, sampled only on the accept edge
//   cin        carry into nibble 0, sampled only on the accept edge
//   out_valid  sum/cout hold a completed result (registered)
//   out_ready  consumer takes the result
//   sum        (a + b + cin) mod 2^WIDTH, held until the next completion
//   cout       carry out of bit WIDTH-1, held until the next completion
module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [WIDTH-1:0]  op_a_q;
   logic [WIDTH-1:0]  op_b_q;
   logic              carry_q;
   logic [IDXW-1:0]   idx_q;
   logic [WIDTH-1:0]  work_q;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q;

   logic [3:0]        nib_a;
   logic [3:0]        nib_b;
   logic [3:0]        slice_s;
   logic              slice_c;
   logic [WIDTH-1:0]  work_d;

   // The only adder in the block: four chained full adders.
   function automatic logic [4:0] slice_add4(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       c);
      logic [3:0] s;
      logic       cc;
      cc = c;
      for (int i = 0; i < 4; i++) begin
         s[i] = x[i] ^ y[i] ^ cc;
         cc   = ((x[i] ^ y[i]) & cc) | (x[i] & y[i]);
      end
      return {cc, s};
   endfunction

   // Nibble select and write-back, unrolled as a compare per nibble so the
   // index never needs a variable part-select.
   always_comb begin
      nib_a  = '0;
      nib_b  = '0;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx_q == IDXW'(n)) begin
            nib_a = op_a_q[4*n +: 4];
            nib_b = op_b_q[4*n +: 4];
         end
      end
      {slice_c, slice_s} = slice_add4(nib_a, nib_b, carry_q);
      work_d = work_q;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx_q == IDXW'(n)) begin
            work_d[4*n +: 4] = slice_s;
         end
      end
   end

   // Operand registers are not reset: they are always loaded before use.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         work_q      <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_a_q     <= a;
                  op_b_q     <= b;
                  carry_q    <= cin;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               work_q  <= work_d;
               carry_q <= slice_c;
               idx_q   <= idx_q + IDXW'(1);
               if (idx_q == LAST_IDX) begin
                  // work_d already contains the nibble produced this cycle.
                  sum_q       <= work_d;
                  cout_q      <= slice_c;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule
